// File: rtl/motion_pkg.sv
// Shared definitions for the maze actor movement controller.
// Holds the direction encoding, wall-flag bit positions, the default tile
// size and a helper returning the reverse of a direction.
package motion_pkg;

  typedef enum logic [2:0] {
    DIR_STOP  = 3'b000,
    DIR_UP    = 3'b100,
    DIR_RIGHT = 3'b101,
    DIR_DOWN  = 3'b110,
    DIR_LEFT  = 3'b111
  } dir_t;

  // Bit positions in adjacent_walls; they equal dir[1:0] of the matching move.
  localparam int unsigned WALL_UP    = 0;
  localparam int unsigned WALL_RIGHT = 1;
  localparam int unsigned WALL_DOWN  = 2;
  localparam int unsigned WALL_LEFT  = 3;

  localparam int unsigned TILE_LOG2_DEF = 4;

  function automatic dir_t opposite_dir(input dir_t d);
    return dir_t'({1'b1, d[1:0] ^ 2'b10});
  endfunction

  // Codes 001..011 carry no movement and are folded onto stop.
  function automatic dir_t norm_dir(input logic [2:0] d);
    return d[2] ? dir_t'(d) : DIR_STOP;
  endfunction

endpackage

// File: rtl/actor_motion_lane.sv
// One actor lane: queued direction, speed divider, pixel position and
// current direction.
// Ports: Clk, Reset_n (async active-low), frame_tick (movement strobe),
//        load (copy start position), start_x/start_y, speed (step every
//        speed+1 ticks), req_valid/req_dir (direction request),
//        adjacent_walls (wall flags of current tile), pos_x/pos_y, dir,
//        aligned (tile alignment, combinational from registers).
// Macro TUNNEL_WRAP_EN: horizontal wrap at the maze edges instead of
// treating the outer columns as walls.
module actor_motion_lane
  import motion_pkg::*;
#(
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned TILE_LOG2 = TILE_LOG2_DEF,
  parameter int unsigned SPEED_W   = 4,
  parameter int unsigned MAZE_W_PX = 448
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_tick,
  input  logic               load,
  input  logic [COORD_W-1:0] start_x,
  input  logic [COORD_W-1:0] start_y,
  input  logic [SPEED_W-1:0] speed,
  input  logic               req_valid,
  input  logic [2:0]         req_dir,
  input  logic [3:0]         adjacent_walls,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [2:0]         dir,
  output logic               aligned
);

`ifdef TUNNEL_WRAP_EN
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(MAZE_W_PX - 1);
`else
  localparam logic [COORD_W-1:0] X_EDGE = COORD_W'(MAZE_W_PX - (1 << TILE_LOG2));
`endif

  dir_t               dir_q, dir_nx;
  dir_t               queue_q, queue_nx;
  logic [SPEED_W-1:0] cnt_q;
  logic [COORD_W-1:0] x_nx, y_nx;
  logic [3:0]         eff_walls;
  logic               step;

  assign aligned = (pos_x[TILE_LOG2-1:0] == '0) && (pos_y[TILE_LOG2-1:0] == '0);
  assign dir     = dir_q;
  assign step    = frame_tick && (cnt_q == speed);

  always_comb begin
    eff_walls = adjacent_walls;
`ifndef TUNNEL_WRAP_EN
    // Outer columns act as walls so the actor never leaves the maze.
    if (pos_x == '0)    eff_walls[WALL_LEFT]  = 1'b1;
    if (pos_x == X_EDGE) eff_walls[WALL_RIGHT] = 1'b1;
`endif
    dir_nx   = dir_q;
    queue_nx = queue_q;
    if (aligned) begin
      if (queue_q != DIR_STOP && !eff_walls[queue_q[1:0]]) begin
        dir_nx   = queue_q;
        queue_nx = DIR_STOP;
      end else if (dir_q != DIR_STOP && eff_walls[dir_q[1:0]]) begin
        dir_nx = DIR_STOP;
      end
    end else if (dir_q != DIR_STOP && queue_q == opposite_dir(dir_q)) begin
      dir_nx   = queue_q;
      queue_nx = DIR_STOP;
    end

    x_nx = pos_x;
    y_nx = pos_y;
    case (dir_nx)
      DIR_UP:    y_nx = pos_y - COORD_W'(1);
      DIR_DOWN:  y_nx = pos_y + COORD_W'(1);
`ifdef TUNNEL_WRAP_EN
      DIR_RIGHT: x_nx = (pos_x == X_MAX) ? '0 : pos_x + COORD_W'(1);
      DIR_LEFT:  x_nx = (pos_x == '0) ? X_MAX : pos_x - COORD_W'(1);
`else
      DIR_RIGHT: x_nx = pos_x + COORD_W'(1);
      DIR_LEFT:  x_nx = pos_x - COORD_W'(1);
`endif
      default:   ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x   <= '0;
      pos_y   <= '0;
      dir_q   <= DIR_STOP;
      queue_q <= DIR_STOP;
      cnt_q   <= '0;
    end else if (load) begin
      pos_x   <= start_x;
      pos_y   <= start_y;
      dir_q   <= DIR_STOP;
      queue_q <= DIR_STOP;
      cnt_q   <= '0;
    end else begin
      if (frame_tick) begin
        if (step) begin
          cnt_q   <= '0;
          pos_x   <= x_nx;
          pos_y   <= y_nx;
          dir_q   <= dir_nx;
          queue_q <= queue_nx;
        end else begin
          cnt_q <= cnt_q + SPEED_W'(1);
        end
      end
      // A request in a step cycle overrides the step's queue update, so it
      // is only acted on at the following step.
      if (req_valid) queue_q <= norm_dir(req_dir);
    end
  end

endmodule

// File: rtl/actor_motion_ctrl.sv
// Movement controller for all maze actors (lane 0 = Pac-Man).
// Ports: Clk, Reset_n (async active-low), frame_tick, load,
//        start_x/start_y (packed per lane), speed (packed per-lane divisor),
//        req_valid/req_dir, adjacent_walls (bit0 up, 1 right, 2 down,
//        3 left), pos_x/pos_y, dir, aligned.
// Macro TUNNEL_WRAP_EN: horizontal tunnel wrap (see actor_motion_lane).
module actor_motion_ctrl
  import motion_pkg::*;
#(
  parameter int unsigned NUM_ACTORS = 4,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned TILE_LOG2  = TILE_LOG2_DEF,
  parameter int unsigned SPEED_W    = 4,
  parameter int unsigned MAZE_W_PX  = 448
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_tick,
  input  logic                          load,
  input  logic [NUM_ACTORS*COORD_W-1:0] start_x,
  input  logic [NUM_ACTORS*COORD_W-1:0] start_y,
  input  logic [NUM_ACTORS*SPEED_W-1:0] speed,
  input  logic [NUM_ACTORS-1:0]         req_valid,
  input  logic [NUM_ACTORS*3-1:0]       req_dir,
  input  logic [NUM_ACTORS*4-1:0]       adjacent_walls,
  output logic [NUM_ACTORS*COORD_W-1:0] pos_x,
  output logic [NUM_ACTORS*COORD_W-1:0] pos_y,
  output logic [NUM_ACTORS*3-1:0]       dir,
  output logic [NUM_ACTORS-1:0]         aligned
);

  for (genvar i = 0; i < NUM_ACTORS; i++) begin : g_lane
    actor_motion_lane #(
      .COORD_W  (COORD_W),
      .TILE_LOG2(TILE_LOG2),
      .SPEED_W  (SPEED_W),
      .MAZE_W_PX(MAZE_W_PX)
    ) u_lane (
      .Clk           (Clk),
      .Reset_n       (Reset_n),
      .frame_tick    (frame_tick),
      .load          (load),
      .start_x       (start_x[i*COORD_W +: COORD_W]),
      .start_y       (start_y[i*COORD_W +: COORD_W]),
      .speed         (speed[i*SPEED_W +: SPEED_W]),
      .req_valid     (req_valid[i]),
      .req_dir       (req_dir[i*3 +: 3]),
      .adjacent_walls(adjacent_walls[i*4 +: 4]),
      .pos_x         (pos_x[i*COORD_W +: COORD_W]),
      .pos_y         (pos_y[i*COORD_W +: COORD_W]),
      .dir           (dir[i*3 +: 3]),
      .aligned       (aligned[i])
    );
  end

endmodule

// File: tb/tb_actor_motion_ctrl.sv
module tb_actor_motion_ctrl;

  localparam int N  = 4;
  localparam int CW = 10;
  localparam int SW = 4;

  localparam logic [2:0] D_STOP  = 3'b000;
  localparam logic [2:0] D_UP    = 3'b100;
  localparam logic [2:0] D_RIGHT = 3'b101;
  localparam logic [2:0] D_DOWN  = 3'b110;
  localparam logic [2:0] D_LEFT  = 3'b111;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_tick;
  logic          load;
  logic [N*CW-1:0] start_x, start_y;
  logic [N*SW-1:0] speed;
  logic [N-1:0]    req_valid;
  logic [N*3-1:0]  req_dir;
  logic [N*4-1:0]  adjacent_walls;
  logic [N*CW-1:0] pos_x, pos_y;
  logic [N*3-1:0]  dir;
  logic [N-1:0]    aligned;

  int n_checks = 0;
  int n_fails  = 0;

  actor_motion_ctrl #(
    .NUM_ACTORS(N),
    .COORD_W   (CW),
    .TILE_LOG2 (4),
    .SPEED_W   (SW),
    .MAZE_W_PX (448)
  ) dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .frame_tick    (frame_tick),
    .load          (load),
    .start_x       (start_x),
    .start_y       (start_y),
    .speed         (speed),
    .req_valid     (req_valid),
    .req_dir       (req_dir),
    .adjacent_walls(adjacent_walls),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .dir           (dir),
    .aligned       (aligned)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] px(input int l); return 32'(pos_x[l*CW +: CW]); endfunction
  function automatic logic [31:0] py(input int l); return 32'(pos_y[l*CW +: CW]); endfunction
  function automatic logic [31:0] pd(input int l); return 32'(dir[l*3 +: 3]); endfunction
  function automatic logic [31:0] pa(input int l); return 32'(aligned[l]); endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge Clk) frame_tick = 1'b1;
      @(negedge Clk) frame_tick = 1'b0;
    end
  endtask

  task automatic do_load();
    @(negedge Clk) load = 1'b1;
    @(negedge Clk) load = 1'b0;
  endtask

  task automatic req(input int l, input logic [2:0] d);
    @(negedge Clk);
    req_valid[l]     = 1'b1;
    req_dir[l*3 +: 3] = d;
    @(negedge Clk);
    req_valid = '0;
  endtask

  initial begin
    Reset_n = 1'b0; frame_tick = 1'b0; load = 1'b0;
    start_x = '0; start_y = '0; speed = '0;
    req_valid = '0; req_dir = '0; adjacent_walls = '0;
    @(negedge Clk);
    chk("rst_x0", px(0), 0);
    chk("rst_y0", py(0), 0);
    chk("rst_dir0", pd(0), 0);
    chk("rst_al0", pa(0), 1);
    Reset_n = 1'b1;

    // Run right one full tile from (16,16).
    start_x[0 +: CW] = 10'd16; start_y[0 +: CW] = 10'd16;
    start_x[CW +: CW] = 10'd64; start_y[CW +: CW] = 10'd16;
    do_load();
    chk("load_x0", px(0), 16);
    req(0, D_RIGHT);
    tick(16);
    chk("run_x0", px(0), 32);
    chk("run_y0", py(0), 16);
    chk("run_dir0", pd(0), 32'(D_RIGHT));
    chk("run_al0", pa(0), 1);
    chk("idle_x1", px(1), 64);

    // Wall ahead stops the actor; a clear turn then restarts it.
    adjacent_walls[3:0] = 4'b0010;
    tick(1);
    chk("wall_dir0", pd(0), 32'(D_STOP));
    chk("wall_x0", px(0), 32);
    req(0, D_DOWN);
    tick(1);
    chk("turn_dir0", pd(0), 32'(D_DOWN));
    chk("turn_y0", py(0), 17);
    chk("turn_x0", px(0), 32);
    chk("turn_al0", pa(0), 0);
    adjacent_walls = '0;

    // Mid-tile reversal.
    do_load();
    req(0, D_RIGHT);
    tick(4);
    chk("pre_rev_x0", px(0), 20);
    req(0, D_LEFT);
    tick(1);
    chk("rev_dir0", pd(0), 32'(D_LEFT));
    chk("rev_x0", px(0), 19);
    tick(4);   // through tile 16: queue empty, keeps going left
    chk("rev_keep_x0", px(0), 15);
    chk("rev_keep_dir0", pd(0), 32'(D_LEFT));

    // Speed divider.
    speed[SW +: SW] = 4'd2;
    do_load();
    req(0, D_RIGHT);
    req(1, D_RIGHT);
    tick(6);
    chk("spd_x0", px(0), 22);
    chk("spd_x1", px(1), 66);
    speed = '0;

    // Left edge of the maze.
    do_load();
    req(0, D_LEFT);
    tick(16);
    chk("edge_x0", px(0), 0);
    chk("edge_dir0", pd(0), 32'(D_LEFT));
    tick(1);
`ifdef TUNNEL_WRAP_EN
    chk("wrap_x0", px(0), 447);
    chk("wrap_dir0", pd(0), 32'(D_LEFT));
    chk("wrap_al0", pa(0), 0);
`else
    chk("edge_stop_x0", px(0), 0);
    chk("edge_stop_dir0", pd(0), 32'(D_STOP));
    chk("edge_stop_al0", pa(0), 1);
`endif
    chk("edge_y0", py(0), 16);

    // Asynchronous reset between clock edges.
    req(0, D_RIGHT);
    tick(2);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_x0", px(0), 0);
    chk("arst_dir0", pd(0), 0);
    chk("arst_x1", px(1), 0);
    chk("arst_y1", py(1), 0);
    @(negedge Clk) Reset_n = 1'b1;

    // load wins over a concurrent frame_tick and clears the queue.
    start_x[0 +: CW] = 10'd48; start_y[0 +: CW] = 10'd32;
    req(0, D_UP);
    @(negedge Clk); load = 1'b1; frame_tick = 1'b1;
    @(negedge Clk); load = 1'b0; frame_tick = 1'b0;
    chk("ldtk_x0", px(0), 48);
    chk("ldtk_y0", py(0), 32);
    chk("ldtk_dir0", pd(0), 0);
    tick(1);
    chk("ldtk_q_y0", py(0), 32);

    // Request in the same cycle as a tick only applies at the next step.
    @(negedge Clk); req_valid[0] = 1'b1; req_dir[2:0] = D_RIGHT; frame_tick = 1'b1;
    @(negedge Clk); req_valid = '0; frame_tick = 1'b0;
    chk("rqtk_x0", px(0), 48);
    chk("rqtk_dir0", pd(0), 0);
    tick(1);
    chk("rqtk2_x0", px(0), 49);
    chk("rqtk2_dir0", pd(0), 32'(D_RIGHT));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
